// File: rtl/reg_operand_stage.sv
// Register-operand stage: 32x32 register file with a power-on clear sweep,
// feeding a one-deep operand holding register toward the ALU.
//
// Ports:
//   clk, rst_n                    - clock, synchronous active-low reset
//   wr_en, wr_addr, wr_data       - register-file write port
//   op_valid / op_ready           - operand request handshake
//   rs_addr, rt_addr, imm16, shamt- request fields
//   srcA_sel, srcB_sel            - operand source selects
//   srcA, srcB, out_valid, out_ack- latched operands toward the ALU
//   init_done                     - register-file clear sweep finished
module reg_operand_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wr_en,
   input  logic [4:0]  wr_addr,
   input  logic [31:0] wr_data,
   input  logic        op_valid,
   output logic        op_ready,
   input  logic [4:0]  rs_addr,
   input  logic [4:0]  rt_addr,
   input  logic [15:0] imm16,
   input  logic [4:0]  shamt,
   input  logic        srcA_sel,
   input  logic [1:0]  srcB_sel,
   output logic [31:0] srcA,
   output logic [31:0] srcB,
   output logic        out_valid,
   input  logic        out_ack,
   output logic        init_done
);

   localparam int unsigned DW     = 32;
   localparam int unsigned AW     = 5;
   localparam int unsigned NREGS  = 32;
   localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

   typedef enum logic [1:0] {S_INIT, S_IDLE, S_HOLD} state_t;

   state_t          r_state;
   logic [AW-1:0]   r_cnt;
   logic [DW-1:0]   r_mem [NREGS];
   logic [DW-1:0]   r_srcA;
   logic [DW-1:0]   r_srcB;
   logic            r_op_ready;
   logic            r_out_valid;
   logic            r_init_done;

   logic            w_wr_ok;
   logic [DW-1:0]   w_rs_val;
   logic [DW-1:0]   w_rt_val;
   logic [DW-1:0]   w_srcA;
   logic [DW-1:0]   w_srcB;

   // External writes only land once the sweep is done; r0 is never written.
   assign w_wr_ok = wr_en && (wr_addr != '0) && (r_state != S_INIT);

   // Register reads with same-cycle write bypass; r0 always reads zero.
   always_comb begin
      w_rs_val = '0;
      w_rt_val = '0;
      if (rs_addr != '0) begin
         w_rs_val = (w_wr_ok && (wr_addr == rs_addr)) ? wr_data : r_mem[rs_addr];
      end
      if (rt_addr != '0) begin
         w_rt_val = (w_wr_ok && (wr_addr == rt_addr)) ? wr_data : r_mem[rt_addr];
      end
   end

   // Operand source selection.
   always_comb begin
      w_srcA = srcA_sel ? w_rt_val : w_rs_val;
      w_srcB = w_rt_val;
      case (srcB_sel)
         2'd0:    w_srcB = w_rt_val;
         2'd1:    w_srcB = {{16{imm16[15]}}, imm16};
         2'd2:    w_srcB = {16'b0, imm16};
         default: w_srcB = {27'b0, shamt};
      endcase
   end

   // Register file storage: sweep clears one entry per INIT cycle.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (r_state == S_INIT) begin
            r_mem[r_cnt] <= '0;
         end else if (w_wr_ok) begin
            r_mem[wr_addr] <= wr_data;
         end
      end
   end

   // Control FSM with registered handshake and operand outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_INIT;
         r_cnt       <= '0;
         r_init_done <= 1'b0;
         r_op_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_srcA      <= '0;
         r_srcB      <= '0;
      end else begin
         case (r_state)
            S_INIT: begin
               r_cnt <= r_cnt + AW'(1);
               if (r_cnt == LAST) begin
                  r_state     <= S_IDLE;
                  r_init_done <= 1'b1;
                  r_op_ready  <= 1'b1;
               end
            end
            S_IDLE: begin
               if (op_valid) begin
                  r_srcA      <= w_srcA;
                  r_srcB      <= w_srcB;
                  r_state     <= S_HOLD;
                  r_op_ready  <= 1'b0;
                  r_out_valid <= 1'b1;
               end
            end
            S_HOLD: begin
               if (out_ack) begin
                  r_state     <= S_IDLE;
                  r_op_ready  <= 1'b1;
                  r_out_valid <= 1'b0;
               end
            end
            default: begin
               r_state     <= S_INIT;
               r_cnt       <= '0;
               r_init_done <= 1'b0;
               r_op_ready  <= 1'b0;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign srcA      = r_srcA;
   assign srcB      = r_srcB;
   assign op_ready  = r_op_ready;
   assign out_valid = r_out_valid;
   assign init_done = r_init_done;

endmodule

// File: tb/tb_reg_operand_stage.sv
// Self-checking bench for reg_operand_stage: directed scenarios plus a
// randomized phase, all compared against a transaction-level model.
module tb_reg_operand_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        op_valid;
   logic        op_ready;
   logic [4:0]  rs_addr;
   logic [4:0]  rt_addr;
   logic [15:0] imm16;
   logic [4:0]  shamt;
   logic        srcA_sel;
   logic [1:0]  srcB_sel;
   logic [31:0] srcA;
   logic [31:0] srcB;
   logic        out_valid;
   logic        out_ack;
   logic        init_done;

   always #5 clk = ~clk;

   reg_operand_stage dut (
      .clk(clk), .rst_n(rst_n),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .op_valid(op_valid), .op_ready(op_ready),
      .rs_addr(rs_addr), .rt_addr(rt_addr), .imm16(imm16), .shamt(shamt),
      .srcA_sel(srcA_sel), .srcB_sel(srcB_sel),
      .srcA(srcA), .srcB(srcB), .out_valid(out_valid), .out_ack(out_ack),
      .init_done(init_done)
   );

   int tests = 0;
   int fails = 0;

   // Model: architectural register contents, sweep cycles left, pending operands.
   logic [31:0] m_mem [32];
   int          m_init_left = 32;
   bit          m_busy = 1'b0;
   logic [31:0] m_a = '0;
   logic [31:0] m_b = '0;

   function automatic logic [31:0] m_rd(input logic [4:0] a);
      return (a == 5'd0) ? 32'd0 : m_mem[a];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      rst_n = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      op_valid = 1'b0; rs_addr = '0; rt_addr = '0; imm16 = '0; shamt = '0;
      srcA_sel = 1'b0; srcB_sel = '0; out_ack = 1'b0;
   endtask

   // One clock: advance the model on the edge's inputs, then compare outputs.
   task automatic step();
      @(posedge clk);
      if (!rst_n) begin
         m_init_left = 32; m_busy = 1'b0; m_a = '0; m_b = '0;
      end else if (m_init_left > 0) begin
         m_init_left--;
         if (m_init_left == 0) foreach (m_mem[i]) m_mem[i] = '0;
      end else begin
         // A write is architecturally visible to a request in the same cycle.
         if (wr_en && wr_addr != 5'd0) m_mem[wr_addr] = wr_data;
         if (!m_busy) begin
            if (op_valid) begin
               m_a = srcA_sel ? m_rd(rt_addr) : m_rd(rs_addr);
               case (srcB_sel)
                  2'd0: m_b = m_rd(rt_addr);
                  2'd1: m_b = 32'($signed(imm16));
                  2'd2: m_b = 32'(imm16);
                  default: m_b = 32'(shamt);
               endcase
               m_busy = 1'b1;
            end
         end else if (out_ack) begin
            m_busy = 1'b0;
         end
      end
      #1;
      check("init_done", 32'(init_done), 32'(m_init_left == 0));
      check("op_ready", 32'(op_ready), 32'(m_init_left == 0 && !m_busy));
      check("out_valid", 32'(out_valid), 32'(m_busy));
      check("srcA", srcA, m_a);
      check("srcB", srcB, m_b);
   endtask

   task automatic do_reset_and_sweep();
      rst_n = 1'b0;
      step();
      check("rst_init_done", 32'(init_done), 32'd0);
      check("rst_srcA", srcA, 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 32; i++) begin
         step();
         check("sweep_len", 32'(init_done), (i < 31) ? 32'd0 : 32'd1);
      end
   endtask

   initial begin
      logic [31:0] held;
      clr();
      rst_n = 1'b0;
      step(); step(); step();
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_op_ready", 32'(op_ready), 32'd0);

      // Sweep, with external writes attempted during INIT (must be ignored).
      rst_n = 1'b1;
      for (int i = 0; i < 32; i++) begin
         wr_en = 1'b1; wr_addr = 5'(i); wr_data = 32'hFFFF_0000 | 32'(i);
         step();
         check("sweep_len", 32'(init_done), (i < 31) ? 32'd0 : 32'd1);
      end
      clr();

      // Every register reads back zero after the sweep.
      for (int i = 0; i < 32; i++) begin
         op_valid = 1'b1; rs_addr = 5'(i); srcB_sel = 2'd3; shamt = 5'($urandom);
         step();
         check("cleared_reg", srcA, 32'd0);
         clr(); out_ack = 1'b1;
         step();
         clr();
      end

      // Write r5 then request with sign-extended immediate.
      wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h1234_5678;
      step(); clr();
      op_valid = 1'b1; rs_addr = 5'd5; srcA_sel = 1'b0; srcB_sel = 2'd1; imm16 = 16'h8000;
      step(); clr();
      check("r5_srcA", srcA, 32'h1234_5678);
      check("r5_srcB_sext", srcB, 32'hFFFF_8000);
      check("r5_out_valid", 32'(out_valid), 32'd1);

      // Hold for 5 cycles while overwriting r5 and scrambling request fields.
      held = srcA;
      for (int i = 0; i < 5; i++) begin
         wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'd0;
         rs_addr = 5'($urandom); op_valid = 1'($urandom); imm16 = 16'($urandom);
         step();
         check("hold_srcA", srcA, held);
         check("hold_op_ready", 32'(op_ready), 32'd0);
      end
      clr(); out_ack = 1'b1;
      step(); clr();
      check("ack_op_ready", 32'(op_ready), 32'd1);
      check("ack_out_valid", 32'(out_valid), 32'd0);
      out_ack = 1'b1;
      step(); clr();
      check("stray_ack_ignored", 32'(op_ready), 32'd1);

      // r5 now 0; zero-extended immediate on B.
      op_valid = 1'b1; rs_addr = 5'd5; srcB_sel = 2'd2; imm16 = 16'h8001;
      step(); clr();
      check("r5_cleared", srcA, 32'd0);
      check("zext_imm", srcB, 32'h0000_8001);
      out_ack = 1'b1; step(); clr();

      // Writes to r0 are dropped.
      wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hDEAD_BEEF;
      step(); clr();
      op_valid = 1'b1; rs_addr = 5'd0; srcB_sel = 2'd3; shamt = 5'd31;
      step(); clr();
      check("r0_zero", srcA, 32'd0);
      check("shamt_zext", srcB, 32'd31);
      out_ack = 1'b1; step(); clr();

      // Same-cycle write and request bypass, on both operand paths.
      wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5_A5A5;
      op_valid = 1'b1; rt_addr = 5'd7; srcA_sel = 1'b1; srcB_sel = 2'd0;
      step(); clr();
      check("bypass_srcB", srcB, 32'hA5A5_A5A5);
      check("bypass_srcA", srcA, 32'hA5A5_A5A5);
      out_ack = 1'b1; step(); clr();

      // Reset during HOLD drops operands and re-sweeps.
      wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h0BAD_F00D;
      step(); clr();
      op_valid = 1'b1; rs_addr = 5'd9;
      step(); clr();
      check("pre_rst_srcA", srcA, 32'h0BAD_F00D);
      do_reset_and_sweep();
      check("post_rst_out_valid", 32'(out_valid), 32'd0);
      op_valid = 1'b1; rs_addr = 5'd9;
      step(); clr();
      check("r9_swept", srcA, 32'd0);
      out_ack = 1'b1; step(); clr();

      // Reset part-way through INIT restarts the sweep from zero.
      rst_n = 1'b0; step(); clr();
      for (int i = 0; i < 10; i++) step();
      do_reset_and_sweep();

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 1500; i++) begin
         rst_n    = ($urandom_range(0, 199) != 0);
         wr_en    = 1'($urandom);
         wr_addr  = 5'($urandom);
         wr_data  = $urandom;
         op_valid = 1'($urandom);
         rs_addr  = 5'($urandom);
         rt_addr  = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom);
         imm16    = 16'($urandom);
         shamt    = 5'($urandom);
         srcA_sel = 1'($urandom);
         srcB_sel = 2'($urandom);
         out_ack  = ($urandom_range(0, 2) == 0);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
